// File: rtl/pingpong_pkg.sv
// pingpong_pkg: shared state and direction encodings for the ping-pong run controller
package pingpong_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ERR   = 2'd3
   } state_t;
   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/pingpong_run_ctrl_tick_prescaler.sv
// tick_prescaler: divides the system clock down to one count-step strobe every TICK_DIV clocks
module tick_prescaler #(
   parameter int TICK_DIV = 33554432,
   parameter int TICK_W   = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clr,
   output logic tick
);
   logic [TICK_W-1:0] pre;
   assign tick = run && (pre == TICK_W'(TICK_DIV - 1));
   // count while running, wrap on the terminal value, freeze otherwise
   always_ff @(posedge clk) begin
      if (rst || clr)
         pre <= '0;
      else if (run)
         pre <= tick ? '0 : pre + 1'b1;
   end
endmodule

// File: rtl/pingpong_run_ctrl.sv
// pingpong_run_ctrl: start/pause/error sequencer and bounded up/down count; PPC_SINGLE_STEP_EN adds step_p
module pingpong_run_ctrl
   import pingpong_pkg::*;
#(
   parameter int CNT_W    = 4,
   parameter int TICK_DIV = 33554432,
   parameter int TICK_W   = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_p,
   input  logic             pause_p,
   input  logic             flip_p,
`ifdef PPC_SINGLE_STEP_EN
   input  logic             step_p,
`endif
   input  logic [CNT_W-1:0] cfg_max,
   input  logic [CNT_W-1:0] cfg_min,
   output logic [CNT_W-1:0] cnt,
   output logic             dir,
   output logic [1:0]       state,
   output logic             cfg_err,
   output logic             tick
);
   state_t           st, st_nx;
   logic [CNT_W-1:0] max_q, min_q, cnt_nx, max_nx, min_nx;
   logic             dir_nx, flip_q, flip_nx, tick_nx;
   logic             pre_tick, pre_clr, step_go, upd, d_eff, d_fin;

`ifdef PPC_SINGLE_STEP_EN
   assign step_go = step_p && (st == ST_PAUSE);
`else
   assign step_go = 1'b0;
`endif

   assign state   = st;
   assign cfg_err = (st == ST_ERR);

   tick_prescaler #(.TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) u_pre (
      .clk  (clk),
      .rst  (rst),
      .run  (st == ST_RUN),
      .clr  (pre_clr),
      .tick (pre_tick)
   );

   // next-state: start overrides everything; a step reflects at the latched bounds
   always_comb begin
      st_nx   = st;
      cnt_nx  = cnt;
      dir_nx  = dir;
      flip_nx = flip_q;
      max_nx  = max_q;
      min_nx  = min_q;
      tick_nx = 1'b0;
      pre_clr = 1'b0;
      upd     = ((st == ST_RUN) && pre_tick) || step_go;
      d_eff   = dir ^ flip_q ^ flip_p;
      d_fin   = (d_eff && cnt == max_q) ? DIR_DOWN : (!d_eff && cnt == min_q) ? DIR_UP : d_eff;
      if (start_p) begin
         flip_nx = 1'b0;
         pre_clr = 1'b1;
         if (cfg_max > cfg_min) begin
            st_nx  = ST_RUN;
            max_nx = cfg_max;
            min_nx = cfg_min;
            cnt_nx = cfg_min;
            dir_nx = DIR_UP;
         end else
            st_nx = ST_ERR;
      end else if (st == ST_RUN || st == ST_PAUSE) begin
         if (upd) begin
            cnt_nx  = d_fin ? cnt + 1'b1 : cnt - 1'b1;
            dir_nx  = d_fin;
            flip_nx = 1'b0;
            tick_nx = 1'b1;
         end else if (flip_p)
            flip_nx = ~flip_q;
         if (pause_p)
            st_nx = (st == ST_RUN) ? ST_PAUSE : ST_RUN;
      end
   end

   // state, count and strobe registers
   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= ST_IDLE;
         cnt    <= '0;
         dir    <= DIR_UP;
         flip_q <= 1'b0;
         max_q  <= '0;
         min_q  <= '0;
         tick   <= 1'b0;
      end else begin
         st     <= st_nx;
         cnt    <= cnt_nx;
         dir    <= dir_nx;
         flip_q <= flip_nx;
         max_q  <= max_nx;
         min_q  <= min_nx;
         tick   <= tick_nx;
      end
   end
endmodule
